// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues icache requests under a credit limit,
// and buffers in-order responses for decode. Optional FETCH_PERF_CNT_EN adds a bubble counter.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        icache_req_valid,
    input  logic        icache_req_ready,
    output logic [31:0] icache_addr,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_resp_data,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_bubble_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   pc_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] inflight_r;
    logic [CW-1:0] drop_r;
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [AW-1:0] tag_head_r;
    logic [AW-1:0] tag_tail_r;
    logic [31:0]   q_pc_r   [DEPTH];
    logic [31:0]   q_inst_r [DEPTH];
    logic [31:0]   tag_r    [DEPTH];
    logic          out_valid_r;
    logic [31:0]   out_pc_r;
    logic [31:0]   out_inst_r;

    logic [CW:0]   credit_sum_s;
    logic          req_valid_s;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] count_after_pop_s;
    logic [CW-1:0] count_next_s;
    logic [CW-1:0] inflight_next_s;
    logic [AW-1:0] head_next_s;
    logic [31:0]   redirect_target_s;
    logic          next_valid_s;
    logic [31:0]   next_pc_s;
    logic [31:0]   next_inst_s;

    // Credit check, handshake decode and the head entry that will be visible next cycle.
    always_comb begin
        credit_sum_s      = {1'b0, count_r} + {1'b0, inflight_r};
        req_valid_s       = reset && !redirect_valid && (credit_sum_s < DEPTH_W);
        accept_s          = req_valid_s && icache_req_ready;
        push_s            = icache_resp_valid && (drop_r == {CW{1'b0}}) && !redirect_valid;
        pop_s             = out_valid_r && !stall;
        count_after_pop_s = count_r - CW'(pop_s);
        count_next_s      = count_after_pop_s + CW'(push_s);
        inflight_next_s   = inflight_r + CW'(accept_s) - CW'(icache_resp_valid);
        redirect_target_s = redirect_pc & 32'hFFFF_FFFC;
        next_valid_s      = 1'b0;
        next_pc_s         = out_pc_r;
        next_inst_s       = NOP;
        if (pop_s) begin
            head_next_s = head_r + AW'(1);
        end else begin
            head_next_s = head_r;
        end
        // An entry landing in an otherwise empty queue bypasses the storage array.
        if (count_next_s == {CW{1'b0}}) begin
            next_valid_s = 1'b0;
        end else if (count_after_pop_s == {CW{1'b0}}) begin
            next_valid_s = 1'b1;
            next_pc_s    = tag_r[tag_head_r];
            next_inst_s  = icache_resp_data;
        end else begin
            next_valid_s = 1'b1;
            next_pc_s    = q_pc_r[head_next_s];
            next_inst_s  = q_inst_r[head_next_s];
        end
    end

    // PC, credit counters, queue and tag FIFO state, plus registered decode outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_r        <= RESET_PC;
            count_r     <= {CW{1'b0}};
            inflight_r  <= {CW{1'b0}};
            drop_r      <= {CW{1'b0}};
            head_r      <= {AW{1'b0}};
            tail_r      <= {AW{1'b0}};
            tag_head_r  <= {AW{1'b0}};
            tag_tail_r  <= {AW{1'b0}};
            out_valid_r <= 1'b0;
            out_pc_r    <= RESET_PC;
            out_inst_r  <= NOP;
        end else if (redirect_valid) begin
            // Everything still outstanding belongs to the old path and must be discarded.
            pc_r        <= redirect_target_s;
            count_r     <= {CW{1'b0}};
            inflight_r  <= inflight_next_s;
            drop_r      <= inflight_next_s;
            head_r      <= {AW{1'b0}};
            tail_r      <= {AW{1'b0}};
            tag_head_r  <= {AW{1'b0}};
            tag_tail_r  <= {AW{1'b0}};
            out_valid_r <= 1'b0;
            out_inst_r  <= NOP;
        end else begin
            if (accept_s) begin
                pc_r              <= pc_r + 32'd4;
                tag_r[tag_tail_r] <= pc_r;
                tag_tail_r        <= tag_tail_r + AW'(1);
            end
            if (icache_resp_valid && (drop_r != {CW{1'b0}})) begin
                drop_r <= drop_r - CW'(1);
            end
            if (push_s) begin
                q_pc_r[tail_r]   <= tag_r[tag_head_r];
                q_inst_r[tail_r] <= icache_resp_data;
                tail_r           <= tail_r + AW'(1);
                tag_head_r       <= tag_head_r + AW'(1);
            end
            head_r      <= head_next_s;
            count_r     <= count_next_s;
            inflight_r  <= inflight_next_s;
            out_valid_r <= next_valid_s;
            out_pc_r    <= next_pc_s;
            out_inst_r  <= next_inst_s;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating count of cycles where decode could accept but nothing is presented.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_bubble_cnt <= 32'h0000_0000;
        end else if (!out_valid_r && !stall && (perf_bubble_cnt != 32'hFFFF_FFFF)) begin
            perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif

    assign icache_req_valid = req_valid_s;
    assign icache_addr      = pc_r;
    assign out_valid        = out_valid_r;
    assign out_pc           = out_pc_r;
    assign out_inst         = out_inst_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a variable-latency icache model, directed fetch
// scenarios pushing expected PCs, and a monitor comparing every instruction decode takes.
module tb_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_2000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        icache_req_valid;
    logic        icache_req_ready;
    logic [31:0] icache_addr;
    logic        icache_resp_valid = 1'b0;
    logic [31:0] icache_resp_data  = 32'h0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    fetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clk              (clk),
        .reset            (reset),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .stall            (stall),
        .icache_req_valid (icache_req_valid),
        .icache_req_ready (icache_req_ready),
        .icache_addr      (icache_addr),
        .icache_resp_valid(icache_resp_valid),
        .icache_resp_data (icache_resp_data),
        .out_valid        (out_valid),
        .out_pc           (out_pc),
        .out_inst         (out_inst)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int lat    = 1;
    int acc_cnt = 0;
    logic [31:0] sb_pc     [$];
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        sb_pc.push_back(pc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // icache model: record accepted requests, return them in order after lat cycles.
    always @(negedge clk) begin
        if (reset && icache_req_valid && icache_req_ready) begin
            pend_addr.push_back(icache_addr);
            pend_due.push_back(cyc + lat);
            acc_cnt++;
        end
    end

    always @(posedge clk) begin
        logic rst_at_edge;
        rst_at_edge = reset;
        #1;
        if (!rst_at_edge) begin
            pend_addr.delete();
            pend_due.delete();
        end
        if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            icache_resp_valid = 1'b1;
            icache_resp_data  = inst_of(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            icache_resp_valid = 1'b0;
            icache_resp_data  = 32'h0;
        end
    end

    // Monitor: every instruction taken by decode must match the scoreboard head.
    always @(negedge clk) begin
        logic [31:0] exp_pc;
        if (out_valid === 1'b1) begin
            if (stall === 1'b0) begin
                if (sb_pc.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_out: got pc %h, expected no output", out_pc);
                end else begin
                    exp_pc = sb_pc.pop_front();
                    check("out_pc", out_pc, exp_pc);
                    check("out_inst", out_inst, inst_of(exp_pc));
                end
            end
        end else begin
            check("nop_when_idle", out_inst, NOP);
        end
    end

    initial begin
        int a0;
        int ov_run;
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        icache_req_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", out_pc, RESET_PC);
        check("rst_out_inst", out_inst, NOP);
        check("rst_req_valid", 32'(icache_req_valid), 32'd0);
        step;

        // T1: streaming fetch, 1-cycle latency
        for (int i = 0; i < 8; i++) expect_pc(32'h0000_2000 + 32'(4 * i));
        reset = 1'b1; icache_req_ready = 1'b1; lat = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) check("first_addr", icache_addr, 32'h0000_2000);
            if (i < 3) check("first_valid_latency", 32'(out_valid), (i == 2) ? 32'd1 : 32'd0);
            step;
        end
        icache_req_ready = 1'b0;
        repeat (6) step;
        check("t1_drain", 32'(sb_pc.size()), 32'd0);

        // T2: stalled decode fills exactly DEPTH credits
        a0 = acc_cnt;
        for (int i = 0; i < 4; i++) expect_pc(32'h0000_2020 + 32'(4 * i));
        stall = 1'b1; icache_req_ready = 1'b1;
        repeat (10) step;
        @(negedge clk);
        check("t2_accepts", 32'(acc_cnt - a0), 32'd4);
        check("t2_req_valid", 32'(icache_req_valid), 32'd0);
        check("t2_out_valid", 32'(out_valid), 32'd1);
        check("t2_out_pc", out_pc, 32'h0000_2020);
        step;

        // T5: full queue released, one pop and one push per cycle
        for (int i = 0; i < 11; i++) expect_pc(32'h0000_2030 + 32'(4 * i));
        stall = 1'b0;
        ov_run = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i < 10 && out_valid === 1'b1) ov_run++;
            step;
        end
        icache_req_ready = 1'b0;
        check("t5_throughput", 32'(ov_run), 32'd10);
        repeat (8) step;
        check("t5_drain", 32'(sb_pc.size()), 32'd0);

        // T3: 3-cycle latency, two stale requests in flight at redirect
        lat = 3; icache_req_ready = 1'b1;
        step; step;
        icache_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
        step;
        redirect_valid = 1'b0; icache_req_ready = 1'b1;
        expect_pc(32'h0000_3000); expect_pc(32'h0000_3004);
        @(negedge clk);
        check("t3_valid_after_redirect", 32'(out_valid), 32'd0);
        check("t3_first_addr", icache_addr, 32'h0000_3000);
        step; step;
        icache_req_ready = 1'b0;
        repeat (10) step;
        check("t3_drain", 32'(sb_pc.size()), 32'd0);

        // T4: redirect coincides with a response; misaligned target
        a0 = acc_cnt;
        lat = 2; icache_req_ready = 1'b1;
        step; step;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_4002;
        step;
        redirect_valid = 1'b0;
        expect_pc(32'h0000_4000); expect_pc(32'h0000_4004);
        step; step;
        icache_req_ready = 1'b0;
        repeat (8) step;
        check("t4_accepts", 32'(acc_cnt - a0), 32'd4);
        check("t4_drain", 32'(sb_pc.size()), 32'd0);

        // T4b: back-to-back redirects, the later target wins
        lat = 3; icache_req_ready = 1'b1;
        step; step;
        icache_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_5000;
        step;
        redirect_pc = 32'h0000_6000;
        step;
        redirect_valid = 1'b0; icache_req_ready = 1'b1;
        expect_pc(32'h0000_6000);
        step;
        icache_req_ready = 1'b0;
        repeat (10) step;
        check("t4b_drain", 32'(sb_pc.size()), 32'd0);

        // T6: reset with two requests in flight
        lat = 3; icache_req_ready = 1'b1;
        step; step;
        icache_req_ready = 1'b0; reset = 1'b0;
        step;
        reset = 1'b1; lat = 1; icache_req_ready = 1'b1;
        expect_pc(32'h0000_2000);
        @(negedge clk);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_out_pc", out_pc, RESET_PC);
        check("t6_restart_addr", icache_addr, 32'h0000_2000);
        check("t6_req_valid", 32'(icache_req_valid), 32'd1);
        step;
        icache_req_ready = 1'b0;
        repeat (8) step;
        check("t6_drain", 32'(sb_pc.size()), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
